// File: rtl/cache_wb_param.sv
// Direct-mapped write-back / write-allocate data cache with req/ack handshakes.
// Define CACHE_WB_STATS_EN to add saturating hit/miss/writeback counters.
module cache_wb_param #(
  parameter int ADDR_W          = 10,
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [7:0]                    cpu_wdata,
  output logic                          cpu_ready,
  output logic                          cpu_done,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_hit,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [32*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [32*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                          mem_ack
`ifdef CACHE_WB_STATS_EN
  ,
  output logic [15:0]                   stat_hits,
  output logic [15:0]                   stat_misses,
  output logic [15:0]                   stat_writebacks
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK) + 2;
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 32 * WORDS_PER_BLOCK;
  localparam int BIT_W = OFF_W + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [7:0]        wdata_q;
  logic              miss_q;

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLK_W-1:0]    data_q [NUM_SETS];

  logic              done_q;
  logic              hit_q;
  logic [31:0]       rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BLK_W-1:0]  mem_wdata_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [BIT_W-1:0]  byte_sh;
  logic [BIT_W-1:0]  word_sh;
  logic              line_hit;
  logic              cmp_hit;
  logic              fill;

  assign idx      = addr_q[OFF_W +: IDX_W];
  assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign byte_sh  = {addr_q[OFF_W-1:0], 3'b000};
  assign word_sh  = {addr_q[OFF_W-1:2], 5'b00000};
  assign line_hit = valid_q[idx] && (tag_q[idx] == req_tag);
  assign cmp_hit  = (state_q == S_COMPARE) && line_hit;
  assign fill     = (state_q == S_ALLOCATE) && mem_ack;

  assign cpu_ready = (state_q == S_IDLE);
  assign cpu_done  = done_q;
  assign cpu_hit   = hit_q;
  assign cpu_rdata = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (cpu_req) state_d = S_COMPARE;
      S_COMPARE: begin
        if (line_hit)          state_d = S_IDLE;
        else if (dirty_q[idx]) state_d = S_WRITEBACK;
        else                   state_d = S_ALLOCATE;
      end
      S_WRITEBACK: if (mem_ack) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack) state_d = S_COMPARE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      miss_q      <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < NUM_SETS; i++) tag_q[i] <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            miss_q  <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (line_hit) begin
            if (we_q) dirty_q[idx] <= 1'b1;
            else      rdata_q <= data_q[idx][word_sh +: 32];
            done_q <= 1'b1;
            hit_q  <= ~miss_q;
          end else begin
            miss_q    <= 1'b1;
            mem_req_q <= 1'b1;
            if (dirty_q[idx]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
              mem_wdata_q <= data_q[idx];
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          // mem_req stays high straight into the fill
          if (mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= req_tag;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (cmp_hit && we_q) data_q[idx][byte_sh +: 8] <= wdata_q;
      else if (fill)       data_q[idx] <= mem_rdata;
    end
  end

`ifdef CACHE_WB_STATS_EN
  logic [15:0] hits_q, misses_q, wbs_q;
  logic        first_cmp;

  assign first_cmp       = (state_q == S_COMPARE) && !miss_q;
  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (first_cmp && line_hit && hits_q != 16'hFFFF)
        hits_q <= hits_q + 16'd1;
      if (first_cmp && !line_hit && misses_q != 16'hFFFF)
        misses_q <= misses_q + 16'd1;
      if (state_q == S_WRITEBACK && mem_ack && wbs_q != 16'hFFFF)
        wbs_q <= wbs_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb_param.sv
// Bench for cache_wb_param: vector table plus scoreboard, memory responder
// with programmable ack delay, and hand sequences for stall and reset cases.
module tb_cache_wb_param;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [9:0]   cpu_addr;
  logic [7:0]   cpu_wdata;
  logic         cpu_ready;
  logic         cpu_done;
  logic [31:0]  cpu_rdata;
  logic         cpu_hit;
  logic         mem_req;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
`ifdef CACHE_WB_STATS_EN
  logic [15:0]  stat_hits, stat_misses, stat_writebacks;
`endif

  cache_wb_param dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_WB_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [7:0]  wd;
    logic [31:0] rd;
    bit          hit;
    int          lat;
    int          mreq;
    logic [9:0]  fa;
    bit          wb;
    logic [9:0]  wa;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t         sb[$];
  vec_t         tbl[11];
  logic [127:0] mem [64];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           mreq_cnt = 0;
  int           ack_delay = 0;
  logic [9:0]   last_fill;
  logic [9:0]   last_wb;
  logic [127:0] first_wb_data;
  bit           seen_wb = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // memory model: acks after ack_delay extra cycles of mem_req
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (mem_req && !reset) begin
        if (cnt == ack_delay) begin
          mem_ack = 1;
          cnt = 0;
          if (mem_we) begin
            mem[mem_addr[9:4]] = mem_wdata;
            last_wb = mem_addr;
            if (!seen_wb) first_wb_data = mem_wdata;
            seen_wb = 1;
          end else begin
            mem_rdata = mem[mem_addr[9:4]];
            last_fill = mem_addr;
          end
        end else cnt++;
      end else cnt = 0;
    end
  end

  // completion monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req) mreq_cnt++;
      if (cpu_done) begin
        if (sb.size() == 0) chk("spurious_done", cpu_done, 0);
        else begin
          e = sb.pop_front();
          chk($sformatf("hit@%h", e.v.addr), cpu_hit, e.v.hit);
          chk($sformatf("lat@%h", e.v.addr), cyc - e.acc + 1, e.v.lat);
          chk($sformatf("mreq@%h", e.v.addr), mreq_cnt, e.v.mreq);
          if (!e.v.we)
            chk($sformatf("rdata@%h", e.v.addr), cpu_rdata, e.v.rd);
          if (e.v.mreq > 0)
            chk($sformatf("fill_addr@%h", e.v.addr), last_fill, e.v.fa);
          if (e.v.wb)
            chk($sformatf("wb_addr@%h", e.v.addr), last_wb, e.v.wa);
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    chk("ready_before_req", cpu_ready, 1);
    cpu_req   = 1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wd;
    mreq_cnt  = 0;
    last_fill = '1;
    last_wb   = '1;
    sb.push_back('{v: v, acc: cyc + 1});
    @(negedge clk);
    cpu_req = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vec_t v;
    for (int n = 0; n < 64; n++)
      for (int w = 0; w < 4; w++)
        mem[n][32*w +: 32] = 32'h1000_0000 | 32'(n << 8) | 32'(w);
    mem[0] = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};

    //             we  addr    wd     rd            hit lat mreq fa      wb wa
    tbl[0]  = '{0, 10'h004, 8'h00, 32'h07060504, 0, 4, 1, 10'h000, 0, 10'h000};
    tbl[1]  = '{1, 10'h006, 8'hAB, 32'h00000000, 1, 2, 0, 10'h000, 0, 10'h000};
    tbl[2]  = '{0, 10'h004, 8'h00, 32'h07AB0504, 1, 2, 0, 10'h000, 0, 10'h000};
    tbl[3]  = '{0, 10'h040, 8'h00, 32'h10000400, 0, 5, 2, 10'h040, 1, 10'h000};
    tbl[4]  = '{0, 10'h04C, 8'h00, 32'h10000403, 1, 2, 0, 10'h000, 0, 10'h000};
    tbl[5]  = '{0, 10'h000, 8'h00, 32'h03020100, 0, 4, 1, 10'h000, 0, 10'h000};
    tbl[6]  = '{0, 10'h004, 8'h00, 32'h07AB0504, 1, 2, 0, 10'h000, 0, 10'h000};
    tbl[7]  = '{1, 10'h01F, 8'h5A, 32'h00000000, 0, 4, 1, 10'h010, 0, 10'h000};
    tbl[8]  = '{0, 10'h01C, 8'h00, 32'h5A000103, 1, 2, 0, 10'h000, 0, 10'h000};
    tbl[9]  = '{0, 10'h05C, 8'h00, 32'h10000503, 0, 5, 2, 10'h050, 1, 10'h010};
    tbl[10] = '{0, 10'h01C, 8'h00, 32'h5A000103, 0, 4, 1, 10'h010, 0, 10'h000};

    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_ready", cpu_ready, 1);
    chk("rst_done", cpu_done, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i]);
      wait_done();
`ifdef CACHE_WB_STATS_EN
      if (i == 3) begin
        chk("stat_hits", stat_hits, 2);
        chk("stat_misses", stat_misses, 2);
        chk("stat_writebacks", stat_writebacks, 1);
      end
`endif
    end
    chk("wb_word1", first_wb_data[63:32], 32'h07AB0504);

    // slow fill: request held stable, stray cpu_req ignored
    ack_delay = 5;
    v = '{0, 10'h024, 8'h00, 32'h10000201, 0, 9, 6, 10'h020, 0, 10'h000};
    issue(v);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 10'h020);
      chk("stall_we", mem_we, 0);
      chk("stall_done", cpu_done, 0);
      cpu_req  = (i < 3);
      cpu_addr = 10'h3F0;
      @(negedge clk);
    end
    cpu_req = 0;
    wait_done();

    // reset while filling
    v = '{0, 10'h034, 8'h00, 32'h10000301, 0, 9, 6, 10'h030, 0, 10'h000};
    issue(v);
    @(negedge clk);
    chk("alloc_req", mem_req, 1);
    @(negedge clk);
    reset = 1;
    sb.delete();
    @(negedge clk);
    reset = 0;
    chk("midrst_req", mem_req, 0);
    chk("midrst_ready", cpu_ready, 1);
    chk("midrst_done", cpu_done, 0);
    ack_delay = 0;
    v = '{0, 10'h004, 8'h00, 32'h07AB0504, 0, 4, 1, 10'h000, 0, 10'h000};
    issue(v);
    wait_done();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
